// File: rtl/uart_rx_os16_if.sv
// uart_rx_os16 consumer-side bundle: received byte, sticky flags, clear strobe.
// master = receiver, slave = byte consumer.
interface uart_rx_os16_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 rdy;
  logic                 rdy_clr;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data,
    output rdy,
    output frame_err,
    output overrun,
    input  rdy_clr
  );

  modport slave (
    input  data,
    input  rdy,
    input  frame_err,
    input  overrun,
    output rdy_clr
  );
endinterface

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver paced by a 16x oversample enable.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote per bit, one tick later.
module uart_rx_os16 #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int OS_RATE     = 16
) (
  input  logic           clk_5m,
  input  logic           rst_n,
  input  logic           clken,
  input  logic           rx,
  uart_rx_os16_if.master rx_if
);

  localparam int CW = $clog2(OS_RATE);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(OS_RATE - 1);
  localparam logic [IW-1:0] I_ONE  = IW'(1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
  // vote window straddles mid-bit, so decide one tick late
  localparam logic [CW-1:0] C_DEC = CW'(OS_RATE / 2 + 1);
  localparam logic [CW-1:0] C_WIN = CW'(OS_RATE / 2 - 1);
`else
  localparam logic [CW-1:0] C_DEC = CW'(OS_RATE / 2);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   smp;
  logic                   early;

  logic shift_en;
  logic fin_ok;
  logic fin_err;

  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 rdy_q;
  logic                 ferr_q;
  logic                 ovr_q;

  // metastability guard on the asynchronous line, idles high
  always_ff @(posedge clk_5m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // last two tick samples feed the 2-of-3 vote
  always_ff @(posedge clk_5m or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else if (clken) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign smp = (hist[1] & hist[0])
             | (hist[1] & rx_s)
             | (hist[0] & rx_s);

  // a high before the vote window is a glitch
  assign early = rx_s && (cnt < C_WIN);
`else
  assign smp   = rx_s;
  assign early = rx_s;
`endif

  // state, sample counter and bit index registers
  always_ff @(posedge clk_5m or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // frame sequencing, advanced only on oversample ticks
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    if (clken) begin
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_n = S_START;
            cnt_n   = C_ONE;
          end
        end
        S_START: begin
          if (cnt == C_DEC) begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = smp ? S_IDLE : S_DATA;
          end else if (early) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt + C_ONE;
          end
        end
        S_DATA: begin
          cnt_n = cnt + C_ONE;
          if (cnt == C_LAST) begin
            idx_n = idx + I_ONE;
            if (idx == I_LAST) begin
              state_n = S_STOP;
            end
          end
        end
        S_STOP: begin
          cnt_n = cnt + C_ONE;
          if (cnt == C_LAST) begin
            state_n = S_IDLE;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // per-tick strobes: shift a data bit or close the frame
  always_comb begin
    shift_en = 1'b0;
    fin_ok   = 1'b0;
    fin_err  = 1'b0;
    if (clken && (cnt == C_LAST)) begin
      unique case (1'b1)
        (state == S_DATA): begin
          shift_en = 1'b1;
        end
        (state == S_STOP): begin
          fin_ok  = smp;
          fin_err = !smp;
        end
        default: begin
        end
      endcase
    end
  end

  // LSB-first shift register
  always_ff @(posedge clk_5m or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {smp, shreg[DATA_BITS-1:1]};
    end
  end

  // sticky result flags; a frame end beats a same-cycle clear
  always_ff @(posedge clk_5m or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      rdy_q  <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (rx_if.rdy_clr) begin
        rdy_q  <= 1'b0;
        ferr_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (fin_ok) begin
        data_q <= shreg;
        rdy_q  <= 1'b1;
        ferr_q <= 1'b0;
        if (rdy_q) begin
          ovr_q <= 1'b1;
        end
      end
      if (fin_err) begin
        ferr_q <= 1'b1;
      end
    end
  end

  assign rx_if.data      = data_q;
  assign rx_if.rdy       = rdy_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: randomized + directed frames, queue scoreboard.
// Model tracks {data,rdy,frame_err,overrun}; monitor checks each change.
module tb_uart_rx_os16;

  localparam int TICK    = 28;
  localparam int BIT_CLK = 16 * TICK;
  localparam int SYNC    = 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_DLY = TICK;
  localparam bit MAJ     = 1'b1;
`else
  localparam int MAJ_DLY = 0;
  localparam bit MAJ     = 1'b0;
`endif

  logic clk_5m = 1'b0;
  logic rst_n  = 1'b0;
  logic clken  = 1'b0;
  logic rx     = 1'b1;

  uart_rx_os16_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_os16 #(
    .DATA_BITS  (8),
    .SYNC_STAGES(SYNC),
    .OS_RATE    (16)
  ) dut (
    .clk_5m(clk_5m),
    .rst_n (rst_n),
    .clken (clken),
    .rx    (rx),
    .rx_if (rx_if)
  );

  always #10 clk_5m = ~clk_5m;

  int cyc = 0;
  bit cen_on = 1'b1;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int chg_cyc = 0;

  logic [10:0] m;
  logic [10:0] exp_q[$];
  string       tag_q[$];

  initial forever begin
    @(posedge clk_5m);
    cyc++;
  end

  // baud generator stand-in: tick edges are those with cyc % 28 == 0
  initial forever begin
    @(posedge clk_5m);
    #1;
    clken = cen_on && (((cyc + 1) % TICK) == 0);
  end

  function automatic logic [10:0] cur_t();
    return {rx_if.data, rx_if.rdy, rx_if.frame_err, rx_if.overrun};
  endfunction

  // monitor: every visible output change must match the queue head
  initial begin
    logic [10:0] prev;
    logic [10:0] cur;
    logic [10:0] e;
    string       t;
    prev = '0;
    forever begin
      @(negedge clk_5m);
      if (mon_en) begin
        cur = cur_t();
        if (cur !== prev) begin
          chg_cyc = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change got=%h was=%h", cur, prev);
          end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL %s got=%h exp=%h", t, cur, e);
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_5m);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic expect_t(input logic [10:0] nt, input string tag);
    if (nt !== m) begin
      exp_q.push_back(nt);
      tag_q.push_back(tag);
    end
    m = nt;
  endtask

  // reference: what one complete frame does to the visible outputs
  task automatic model_frame(input logic [7:0] b, input bit stop,
                             input bit clr, input string tag);
    logic [7:0] d;
    logic r;
    logic fe;
    logic ov;
    logic r_old;
    {d, r, fe, ov} = m;
    r_old = r;
    if (clr) begin
      r  = 1'b0;
      fe = 1'b0;
      ov = 1'b0;
    end
    if (stop) begin
      d  = b;
      r  = 1'b1;
      fe = 1'b0;
      if (r_old) ov = 1'b1;
    end else begin
      fe = 1'b1;
    end
    expect_t({d, r, fe, ov}, tag);
  endtask

  task automatic clr_pulse(input string tag);
    expect_t({m[10:3], 3'b000}, tag);
    rx_if.rdy_clr = 1'b1;
    tick();
    rx_if.rdy_clr = 1'b0;
    tick();
  endtask

  // drive one 8N1 frame; gmask inverts rx around the mid-bit sample
  // of data bit j (j<8) or the stop bit (j==8); clr lands on frame end
  task automatic send_byte(input logic [7:0] b, input bit stop,
                           input logic [8:0] gmask, input bit clr,
                           input string tag, output int n0);
    logic [9:0] bits;
    logic [7:0] eb;
    bit es;
    int n;
    int t0;
    int fin;
    bits = {stop, b, 1'b0};
    eb = MAJ ? b : (b ^ gmask[7:0]);
    es = MAJ ? stop : (stop ^ gmask[8]);
    model_frame(eb, es, clr, tag);
    n   = cyc;
    n0  = n;
    t0  = ((n + SYNC + 1 + TICK - 1) / TICK) * TICK;
    fin = t0 + 152 * TICK + MAJ_DLY;
    for (int i = 0; i < 10 * BIT_CLK; i++) begin
      int c;
      int s;
      logic v;
      c = n + i;
      v = bits[i / BIT_CLK];
      for (int j = 0; j < 9; j++) begin
        s = t0 + (24 + 16 * j) * TICK;
        if (gmask[j] && c >= s - 14 && c < s + 10) v = ~v;
      end
      rx = v;
      rx_if.rdy_clr = clr && (c == fin - 1);
      tick();
    end
    rx = 1'b1;
    rx_if.rdy_clr = 1'b0;
    if (!stop) idle(BIT_CLK + 100);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 6000 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got=%0d pending exp=0", tag, exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  initial begin
    int n0;
    int lat;
    logic [7:0] b;
    bit stop;
    rx = 1'b1;
    rx_if.rdy_clr = 1'b0;
    rst_n = 1'b0;
    m = '0;
    repeat (5) tick();
    check("reset_data", rx_if.data, 8'h00);
    check("reset_rdy", rx_if.rdy, 1'b0);
    check("reset_ferr", rx_if.frame_err, 1'b0);
    check("reset_ovr", rx_if.overrun, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    mon_en = 1'b1;

    send_byte(8'hA5, 1'b1, 9'h000, 1'b0, "single_a5", n0);
    wait_drain("single_a5");
    lat = chg_cyc - n0;
    checks++;
    if (lat < 152 * TICK - TICK ||
        lat > 152 * TICK + TICK + SYNC + MAJ_DLY) begin
      errors++;
      $display("FAIL latency got=%0d exp=%0d+-%0d", lat, 152 * TICK, TICK);
    end
    idle(200);

    clr_pulse("clr_a5");
    rx = 1'b0;
    repeat (3 * TICK) tick();
    idle(600);
    check("glitch_rdy", rx_if.rdy, 1'b0);
    check("glitch_hold", cur_t(), m);
    send_byte(8'h3C, 1'b1, 9'h000, 1'b0, "after_glitch", n0);
    wait_drain("after_glitch");

    send_byte(8'h55, 1'b0, 9'h000, 1'b0, "ferr_55", n0);
    wait_drain("ferr_55");
    check("ferr_state", cur_t(), {8'h3C, 3'b110});
    clr_pulse("ferr_clr");
    wait_drain("ferr_clr");
    check("ferr_cleared", rx_if.frame_err, 1'b0);

    send_byte(8'h12, 1'b1, 9'h000, 1'b0, "ovr_12", n0);
    send_byte(8'h34, 1'b1, 9'h000, 1'b0, "ovr_34", n0);
    check("ovr_34_state", cur_t(), {8'h34, 3'b101});
    send_byte(8'h56, 1'b1, 9'h000, 1'b1, "ovr_56_clr", n0);
    wait_drain("ovr");
    check("ovr_set_wins", cur_t(), {8'h56, 3'b101});
    clr_pulse("ovr_clr");
    wait_drain("ovr_clr");

    rx = 1'b0;
    repeat (BIT_CLK) tick();
    rx = 1'b1;
    repeat (4 * BIT_CLK + BIT_CLK / 2) tick();
    expect_t('0, "reset_mid");
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_mid_out", cur_t(), 11'h000);
    rst_n = 1'b1;
    idle(6 * BIT_CLK);
    send_byte(8'h81, 1'b1, 9'h000, 1'b0, "after_reset", n0);
    wait_drain("after_reset");
    check("after_reset_state", cur_t(), {8'h81, 3'b100});

    clr_pulse("maj_clr_a");
    send_byte(8'hC3, 1'b1, 9'h0FF, 1'b0, "vote_data", n0);
    wait_drain("vote_data");
    check("vote_data_state", cur_t(),
          MAJ ? {8'hC3, 3'b100} : {8'h3C, 3'b100});
    clr_pulse("maj_clr_b");
    send_byte(8'hC3, 1'b1, 9'h1FF, 1'b0, "vote_stop", n0);
    wait_drain("vote_stop");
    check("vote_stop_state", cur_t(),
          MAJ ? {8'hC3, 3'b100} : {8'h3C, 3'b010});

    cen_on = 1'b0;
    repeat (2) tick();
    rx = 1'b0;
    repeat (600) tick();
    rx = 1'b1;
    repeat (100) tick();
    cen_on = 1'b1;
    idle(600);
    check("clken_freeze", cur_t(), m);

    for (int r = 0; r < 4; r++) begin
      if ($urandom_range(0, 2) == 0) clr_pulse("rand_clr");
      idle($urandom_range(0, 500));
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_byte(b, stop, 9'h000, 1'b0, "rand_frame", n0);
    end
    wait_drain("rand");
    check("final_state", cur_t(), m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
